spi_shift_engine: RTL and testbench

//   Parametrised SPI master shift engine behind the Wishbone SPI register file.
//   - Supports all four CPOL/CPHA modes, MSB-/LSB-first order, variable char length.
//   - Programmable SCK divider and NUM_SS one-hot-capable slave selects.
//   - Drives sck_o/mosi_o/ss_n_o and samples miso_i as seen on the spi_if bus.

---
 rtl/spi_shift_engine.sv | 140 ++++++++++++++
 tb/tb_spi_shift_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one character per start, all CPOL/CPHA modes,
// programmable bit order, character length, SCK divider and slave selects.
module spi_shift_engine #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 16,
   parameter int LEN_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsb_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [NUM_SS-1:0] ss_sel_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sck_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_SS-1:0] ss_n_o
);

   // edge_reg counts SCK edges already issued: 0 .. 2N-1
   localparam int EC_W = LEN_W + 1;

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

   state_t             state_reg, state_next;
   logic [DATA_W-1:0]  tx_reg, rx_shift_reg, rx_data_reg;
   logic [LEN_W-1:0]   nm1_reg;
   logic               cpol_reg, cpha_reg, lsb_reg;
   logic [DIV_W-1:0]   div_reg, cnt_reg;
   logic [NUM_SS-1:0]  ss_sel_reg;
   logic [EC_W-1:0]    edge_reg;
   logic               sck_reg, mosi_reg;

   logic               accept, tick, leading, last_edge, sample_now, drive_now;
   logic [LEN_W-1:0]   nm1_in, first_pos, half_idx, drv_idx, smp_pos, drv_pos;

   always_comb begin
      state_next = state_reg;
      accept     = start_i && (state_reg == IDLE || state_reg == DONE);
      tick       = (cnt_reg == div_reg);
      leading    = ~edge_reg[0];
      last_edge  = (edge_reg == {nm1_reg, 1'b1});
      // cpha=0 samples on leading edges, cpha=1 on trailing edges
      sample_now = leading ^ cpha_reg;
      drive_now  = ~sample_now && !(last_edge && !cpha_reg);
      nm1_in     = (len_i == '0) ? LEN_W'(DATA_W - 1) : len_i - LEN_W'(1);
      first_pos  = lsb_i ? '0 : nm1_in;
      half_idx   = edge_reg[EC_W-1:1];
      drv_idx    = cpha_reg ? half_idx : half_idx + LEN_W'(1);
      smp_pos    = lsb_reg ? half_idx : nm1_reg - half_idx;
      drv_pos    = lsb_reg ? drv_idx : nm1_reg - drv_idx;

      case (state_reg)
         IDLE:    if (start_i) state_next = LEAD;
         LEAD:    if (tick) state_next = SHIFT;
         SHIFT:   if (tick && last_edge) state_next = TRAIL;
         TRAIL:   if (tick) state_next = DONE;
         DONE:    state_next = start_i ? LEAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_reg       <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         nm1_reg      <= '0;
         cpol_reg     <= 1'b0;
         cpha_reg     <= 1'b0;
         lsb_reg      <= 1'b0;
         div_reg      <= '0;
         ss_sel_reg   <= '0;
         cnt_reg      <= '0;
         edge_reg     <= '0;
         sck_reg      <= 1'b0;
         mosi_reg     <= 1'b0;
      end else if (accept) begin
         tx_reg       <= tx_data_i;
         rx_shift_reg <= '0;
         nm1_reg      <= nm1_in;
         cpol_reg     <= cpol_i;
         cpha_reg     <= cpha_i;
         lsb_reg      <= lsb_i;
         div_reg      <= div_i;
         ss_sel_reg   <= ss_sel_i;
         cnt_reg      <= '0;
         edge_reg     <= '0;
         sck_reg      <= cpol_i;
         if (!cpha_i) mosi_reg <= tx_data_i[first_pos];
      end else begin
         case (state_reg)
            IDLE: sck_reg <= cpol_i;
            LEAD, SHIFT: begin
               if (tick) begin
                  cnt_reg  <= '0;
                  sck_reg  <= ~sck_reg;
                  edge_reg <= edge_reg + EC_W'(1);
                  if (sample_now) rx_shift_reg[smp_pos] <= miso_i;
                  if (drive_now)  mosi_reg <= tx_reg[drv_pos];
               end else begin
                  cnt_reg <= cnt_reg + DIV_W'(1);
               end
            end
            TRAIL: begin
               sck_reg <= cpol_reg;
               // publish the character together with the done pulse
               if (tick) begin
                  cnt_reg     <= '0;
                  rx_data_reg <= rx_shift_reg;
               end else begin
                  cnt_reg <= cnt_reg + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o    = (state_reg == LEAD) || (state_reg == SHIFT) || (state_reg == TRAIL);
   assign done_o    = (state_reg == DONE);
   assign rx_data_o = rx_data_reg;
   assign sck_o     = sck_reg;
   assign mosi_o    = mosi_reg;
   assign ss_n_o    = busy_o ? ~ss_sel_reg : '1;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with loopback and a simple SPI slave model.
module tb_spi_shift_engine;

   logic       clk = 1'b0;
   logic       rst, start, cpol, cpha, lsb, miso;
   logic [7:0] tx;
   logic [2:0] len;
   logic [15:0] div;
   logic [3:0] sel;
   logic       busy, done, sck, mosi;
   logic [7:0] rx;
   logic [3:0] ss_n;

   int vectors = 0;
   int miscompares = 0;

   // slave model state
   logic       loopback = 1'b1;
   logic [7:0] slv_data = 8'h00;
   int         slv_n = 8;
   logic       slv_lsb = 1'b0;
   int         slv_b, slv_idx;

   // bus observer
   int          sck_edges = 0;
   logic        sck_prev = 1'b0;
   logic [15:0] mosi_cap = 16'h0;

   spi_shift_engine dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx), .len_i(len),
      .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb), .div_i(div), .ss_sel_i(sel),
      .busy_o(busy), .done_o(done), .rx_data_o(rx), .sck_o(sck), .mosi_o(mosi),
      .miso_i(miso), .ss_n_o(ss_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      sck_prev <= sck;
      if (!busy) begin
         sck_edges <= 0;
      end else if (sck != sck_prev) begin
         sck_edges <= sck_edges + 1;
         if ((sck != cpol) ^ cpha) mosi_cap <= {mosi_cap[14:0], mosi};
      end
   end

   always_comb begin
      miso    = 1'b0;
      slv_b   = sck_edges / 2;
      slv_idx = slv_lsb ? slv_b : slv_n - 1 - slv_b;
      if (loopback) miso = mosi;
      else if (slv_b < slv_n) miso = slv_data[slv_idx[2:0]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input logic [3:0] t_sel, output int ss_cnt, output int edges);
      int i;
      ss_cnt = 0;
      i = 0;
      while (!done && i < 3000) begin
         if (ss_n == ~t_sel) ss_cnt++;
         @(negedge clk);
         i++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
      edges = sck_edges;
   endtask

   task automatic do_xfer(input logic [7:0] t_tx, input logic [2:0] t_len, input logic t_cpol,
                          input logic t_cpha, input logic t_lsb, input logic [15:0] t_div,
                          input logic [3:0] t_sel, output int ss_cnt, output int edges);
      tx = t_tx; len = t_len; cpol = t_cpol; cpha = t_cpha; lsb = t_lsb; div = t_div; sel = t_sel;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(t_sel, ss_cnt, edges);
   endtask

   initial begin
      int ss_cnt, edges, dones;
      rst = 1'b1; start = 1'b0; tx = '0; len = '0; cpol = 1'b0; cpha = 1'b0;
      lsb = 1'b0; div = '0; sel = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_rx",   {24'b0, rx},   32'h0);
      check("rst_sck",  {31'b0, sck},  32'd0);
      check("rst_mosi", {31'b0, mosi}, 32'd0);
      check("rst_ss_n", {28'b0, ss_n}, 32'hF);
      rst = 1'b0;
      @(negedge clk);
      $display("reset state checked");

      // T1: mode 0, full length, loopback
      do_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1, 4'b0001, ss_cnt, edges);
      check("t1_ss_low", ss_cnt, 32'd34);
      check("t1_edges",  edges,  32'd16);
      check("t1_rx",     {24'b0, rx}, 32'hA5);
      check("t1_ss_done", {28'b0, ss_n}, 32'hF);
      @(negedge clk);
      check("t1_single_done", {31'b0, done}, 32'd0);
      check("t1_idle_busy",   {31'b0, busy}, 32'd0);
      $display("T1 mode0 tx=a5 rx=%0h edges=%0d ss_low=%0d", rx, edges, ss_cnt);

      // T2: mode 3, LSB first, slave returns 0x81
      loopback = 1'b0; slv_data = 8'h81; slv_n = 8; slv_lsb = 1'b1;
      do_xfer(8'h3C, 3'd0, 1'b1, 1'b1, 1'b1, 16'd1, 4'b0010, ss_cnt, edges);
      check("t2_rx",    {24'b0, rx}, 32'h81);
      check("t2_mosi",  {24'b0, mosi_cap[7:0]}, 32'h3C);
      check("t2_edges", edges, 32'd16);
      check("t2_ss_low", ss_cnt, 32'd34);
      @(negedge clk);
      check("t2_sck_idle", {31'b0, sck}, 32'd1);
      $display("T2 mode3 lsb tx=3c rx=%0h mosi_bits=%0h", rx, mosi_cap[7:0]);

      // T3: mode 1, 4-bit character, slave sends 0xF
      slv_data = 8'h0F; slv_n = 4; slv_lsb = 1'b0;
      do_xfer(8'hF9, 3'd4, 1'b0, 1'b1, 1'b0, 16'd1, 4'b1000, ss_cnt, edges);
      check("t3_rx",    {24'b0, rx}, 32'h0F);
      check("t3_mosi",  {28'b0, mosi_cap[3:0]}, 32'h9);
      check("t3_edges", edges, 32'd8);
      check("t3_ss_low", ss_cnt, 32'd18);
      @(negedge clk);
      check("t3_sck_idle", {31'b0, sck}, 32'd0);
      $display("T3 mode1 len4 tx=f9 rx=%0h edges=%0d", rx, edges);

      // T4: start mid-transfer ignored, start held through done chains a second transfer
      loopback = 1'b1;
      tx = 8'h5A; len = 3'd0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; div = 16'd1; sel = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      tx = 8'hC3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_still_busy", {31'b0, busy}, 32'd1);
      repeat (15) @(negedge clk);
      start = 1'b1;
      wait_done(4'b0001, ss_cnt, edges);
      check("t4_rx_first", {24'b0, rx}, 32'h5A);
      check("t4_ss_gap",   {28'b0, ss_n}, 32'hF);
      @(negedge clk);
      start = 1'b0;
      check("t4_rechain_busy", {31'b0, busy}, 32'd1);
      check("t4_rechain_ss",   {28'b0, ss_n}, 32'hE);
      wait_done(4'b0001, ss_cnt, edges);
      check("t4_rx_second", {24'b0, rx}, 32'hC3);
      check("t4_ss_low2",   ss_cnt, 32'd34);
      @(negedge clk);
      check("t4_no_queue", {31'b0, busy}, 32'd0);
      $display("T4 chained transfers rx2=%0h ss_low=%0d", rx, ss_cnt);

      // T5: asynchronous reset after three bits, mode 2 so a stale SCK would be high
      tx = 8'hFF; cpol = 1'b1; cpha = 1'b0; sel = 4'b0011;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("t5_pre_busy", {31'b0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_ss_n", {28'b0, ss_n}, 32'hF);
      check("t5_sck",  {31'b0, sck},  32'd0);
      check("t5_busy", {31'b0, busy}, 32'd0);
      check("t5_rx",   {24'b0, rx},   32'h0);
      check("t5_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("t5_no_done", dones, 32'd0);
      $display("T5 reset abort dones=%0d", dones);

      // T6: divider 0, one slave selected
      do_xfer(8'h96, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0100, ss_cnt, edges);
      check("t6_ss_low", ss_cnt, 32'd17);
      check("t6_edges",  edges,  32'd16);
      check("t6_rx",     {24'b0, rx}, 32'h96);
      $display("T6 div0 rx=%0h edges=%0d ss_low=%0d", rx, edges, ss_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
